// File: rtl/exp_lookup_arbiter.sv
// exp_lookup_arbiter: round-robin sharing of one combinational exp unit among NUM_REQ requesters,
// with a registered operand, one-cycle capture of e^x and a per-requester valid/ready response.
module exp_lookup_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_x,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [W-1:0]         rsp_data,
  output logic [W-1:0]         exp_x,
  input  logic [W-1:0]         exp_y,
  output logic                 busy,
  output logic [15:0]          lookups_done
);
  localparam int GW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;
  state_e               state_q;
  logic [GW-1:0]        grant_q, last_q, gnt_d, idx_d;
  logic                 found_d;
  logic [W-1:0]         exp_x_q, rsp_data_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 busy_q;
  logic [15:0]          done_q;
  logic [W-1:0]         x_a [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_x
    assign x_a[i] = req_x[i*W +: W];
  end
  // first valid requester after the most recent grant, wrapping around
  always_comb begin
    gnt_d = last_q;
    idx_d = last_q;
    found_d = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_d = GW'((int'(last_q) + k) % NUM_REQ);
      if (!found_d && req_valid[idx_d]) begin
        found_d = 1'b1;
        gnt_d = idx_d;
      end
    end
  end
  assign req_ready    = (state_q == IDLE && found_d && !rst) ? NUM_REQ'(1) << gnt_d : '0;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign exp_x        = exp_x_q;
  assign busy         = busy_q;
  assign lookups_done = done_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      exp_x_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (found_d) begin
          exp_x_q <= x_a[gnt_d];
          grant_q <= gnt_d;
          last_q  <= gnt_d;
          busy_q  <= 1'b1;
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          rsp_data_q  <= exp_y;
          rsp_valid_q <= NUM_REQ'(1) << grant_q;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready[grant_q]) begin
          rsp_valid_q <= '0;
          done_q      <= done_q + 16'd1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exp_lookup_arbiter.sv
// tb_exp_lookup_arbiter: scoreboard bench with a round-robin reference model and a real-valued exp unit.
module tb_exp_lookup_arbiter;
  localparam int N = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [N*16-1:0] req_x = '0;
  logic [15:0]   rsp_data, exp_x, exp_y, lookups_done;
  logic          busy;
  exp_lookup_arbiter #(.NUM_REQ(N), .W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .exp_x(exp_x),
    .exp_y(exp_y), .busy(busy), .lookups_done(lookups_done)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] exp_ref(input logic [15:0] x);
    int xi;
    real r;
    xi = int'($signed(x));
    if (xi > 0) xi = 0;
    if (xi < -10240) xi = -10240;
    r = $exp(real'(xi) / 1024.0) * 1024.0;
    return 16'(int'(r));
  endfunction
  assign exp_y = exp_ref(exp_x);
  typedef struct {int idx; logic [15:0] y; int acc;} ent_t;
  ent_t        sb[$];
  logic [15:0] logq[$];
  int          tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", n, got, want, cyc);
    end
  endtask
  task automatic chk_tol(input string n, input int k, input int want);
    tests++;
    if (k >= logq.size()) begin
      fails++;
      $display("FAIL %s no response captured, want=%0h", n, want);
    end else if (int'(logq[k]) - want > 1 || want - int'(logq[k]) > 1) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h +-1", n, logq[k], want);
    end
  endtask
  // monitor: pops the scoreboard on every response handshake
  initial begin
    bit seen = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) seen = 0;
      else if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_rsp got=%0h want=0", rsp_valid);
        end else begin
          chk("rsp_valid", 32'(rsp_valid), 32'(4'(1) << sb[0].idx));
          chk("rsp_data", 32'(rsp_data), 32'(sb[0].y));
          if (!seen) chk("latency", cyc - sb[0].acc, 2);
          seen = 1;
          if (rsp_ready[sb[0].idx]) begin
            logq.push_back(rsp_data);
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end else if (sb.size() != 0 && cyc >= sb[0].acc + 2) begin
        tests++; fails++;
        $display("FAIL missing_rsp got=0 want=%0h", 4'(1) << sb[0].idx);
      end
    end
  end
  // reference model state: one lookup in flight at most, round-robin pointer, handshake count
  logic [N-1:0] rv = '0, rrdy = '1, persist = '0;
  logic [15:0]  rx [N] = '{default: 16'h0};
  bit           rand_en = 0, outst = 0, accepted = 0;
  int           oidx = 0, oacc = 0, last = N - 1;
  logic [15:0]  ox = '0, cnt = '0;
  function automatic int pick(input logic [N-1:0] v, input int from);
    for (int k = 1; k <= N; k++) if (v[(from + k) % N]) return (from + k) % N;
    return 0;
  endfunction
  function automatic logic [15:0] rand_x();
    int v;
    case ($urandom_range(7))
      0: return 16'h8000;
      1: return 16'($urandom_range(32767));
      default: begin v = $urandom_range(10240); return 16'(-v); end
    endcase
  endfunction
  task automatic step();
    logic [N-1:0] er;
    int g;
    @(negedge clk);
    if (rand_en) for (int i = 0; i < N; i++) begin
      if (!rv[i]) begin
        if ($urandom_range(3) == 0) begin rv[i] = 1'b1; rx[i] = rand_x(); end
      end else if ($urandom_range(31) == 0) rv[i] = 1'b0;
      rrdy[i] = $urandom_range(2) != 0;
    end
    req_valid = rv;
    rsp_ready = rrdy;
    for (int i = 0; i < N; i++) req_x[i*16 +: 16] = rx[i];
    #1;
    er = '0;
    g = 0;
    if (!outst && rv != '0) begin g = pick(rv, last); er[g] = 1'b1; end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(outst));
    chk("lookups_done", 32'(lookups_done), 32'(cnt));
    if (outst) chk("exp_x", 32'(exp_x), 32'(ox));
    if (er != '0) begin
      sb.push_back('{g, exp_ref(rx[g]), cyc});
      outst = 1; oidx = g; oacc = cyc; ox = rx[g]; last = g; accepted = 1;
      if (persist[g]) rx[g] = rand_x();
      else rv[g] = 1'b0;
    end else if (outst && cyc >= oacc + 2 && rrdy[oidx]) begin
      outst = 0;
      cnt++;
    end
  endtask
  task automatic chk_zero();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_exp_x", 32'(exp_x), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lookups_done", 32'(lookups_done), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #3 rst = 1'b1;
    req_valid = '0;
    #1 chk_zero();
    sb.delete();
    outst = 0; last = N - 1; cnt = '0;
    @(negedge clk);
    #3 rst = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    int b, t;
    #3 chk_zero();
    @(negedge clk);
    #3 rst = 1'b0;
    // single lookup of e^0
    b = logq.size();
    rv = 4'b0001; rx[0] = 16'h0000;
    run(6);
    chk_tol("t1_exp0", b, 16'h0400);
    // all four from reset, grants in index order
    do_reset();
    b = logq.size();
    rv = 4'b1111;
    rx[0] = 16'h0000; rx[1] = 16'hFC00; rx[2] = 16'hF800; rx[3] = 16'hF400;
    run(16);
    chk_tol("t2_e0", b, 16'h0400);
    chk_tol("t2_em1", b + 1, 16'h0179);
    chk_tol("t2_em2", b + 2, 16'h008A);
    chk_tol("t2_em3", b + 3, 16'h0033);
    // response back-pressure while another requester waits
    rv = 4'b1010; rx[1] = 16'hFE00; rx[3] = 16'hFF00;
    rrdy = 4'b1101;
    run(8);
    rrdy = '1;
    run(8);
    // two continuous requesters alternate at three cycles per lookup
    persist = 4'b0101; rv = 4'b0101; rx[0] = rand_x(); rx[2] = rand_x();
    run(24);
    persist = '0; rv = '0;
    run(4);
    // reset during LOOKUP drops the lookup
    rv = 4'b0100; rx[2] = 16'hF000;
    accepted = 0;
    t = 0;
    while (!accepted && t < 8) begin step(); t++; end
    chk("t5_accept_seen", 32'(accepted), 1);
    do_reset();
    rv = 4'b0110; rx[1] = 16'hFA00; rx[2] = 16'hF000;
    run(10);
    // clamp boundaries
    do_reset();
    b = logq.size();
    rv = 4'b0111; rx[0] = 16'hD800; rx[1] = 16'h8000; rx[2] = 16'h0400;
    run(12);
    chk_tol("t6_m10", b, 16'h0000);
    chk_tol("t6_min", b + 1, 16'h0000);
    chk_tol("t6_pos", b + 2, 16'h0400);
    // randomized traffic with occasional resets
    rand_en = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) do_reset();
      step();
    end
    rand_en = 0; rv = '0; rrdy = '1;
    run(8);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
